// File: rtl/pll_hb_pkg.sv
// pll_hb_pkg: state encodings and FSM state type shared by the heartbeat generator.
package pll_hb_pkg;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_LOST   = 2'd3;
  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SETTLE = ST_SETTLE,
    RUN    = ST_RUN,
    LOST   = ST_LOST
  } hb_state_t;
endpackage

// File: rtl/pll_lock_sync.sv
// pll_lock_sync: generic 2-flop synchroniser, async active-low reset to 0.
module pll_lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, meta} <= 2'b00;
    else        {q, meta} <= {meta, d};
endmodule

// File: rtl/pll_lock_heartbeat.sv
// pll_lock_heartbeat: lock-qualified multi-channel LED heartbeat driven by divider taps.
// Define PLL_HB_LOSS_COUNT_EN to build the saturating lock-loss counter; otherwise loss_cnt_o is 0.
module pll_lock_heartbeat
  import pll_hb_pkg::*;
#(
  parameter int CNT_W      = 27,
  parameter int N_CH       = 4,
  parameter int TAP_BASE   = 22,
  parameter int SETTLE_CYC = 1024,
  parameter int LOSS_W     = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pll_lock_i,
  input  logic              en_i,
  output logic [N_CH-1:0]   led_o,
  output logic              locked_o,
  output logic [1:0]        state_o,
  output logic [LOSS_W-1:0] loss_cnt_o
);
  localparam int SW = SETTLE_CYC > 1 ? $clog2(SETTLE_CYC) : 1;
  if (!(TAP_BASE < CNT_W && TAP_BASE >= N_CH - 1 && SETTLE_CYC >= 1)) begin : g_bad_cfg
    $fatal(1, "pll_lock_heartbeat: invalid TAP_BASE/N_CH/CNT_W/SETTLE_CYC");
  end
  hb_state_t        state, state_n;
  logic             lock_s;
  logic [SW-1:0]    settle, settle_n;
  logic [CNT_W-1:0] div, div_n;
  logic [N_CH-1:0]  led_n;
  logic             settle_done;
  pll_lock_sync u_sync (
    .clk   (clk_i),
    .rst_n (rst_i),
    .d     (pll_lock_i),
    .q     (lock_s)
  );
  assign settle_done = settle == SW'(SETTLE_CYC - 1);
  // Lock loss takes priority over settle completion.
  always_comb begin
    state_n = state == IDLE   ? (lock_s ? SETTLE : IDLE) :
              state == SETTLE ? (!lock_s ? IDLE : settle_done ? RUN : SETTLE) :
              state == RUN    ? (lock_s ? RUN : LOST) : IDLE;
    settle_n = (state == SETTLE && state_n == SETTLE) ? settle + SW'(1) : '0;
    div_n    = (state == RUN && state_n == RUN) ? div + CNT_W'(en_i) : '0;
    led_n    = '0;
    for (int k = 0; k < N_CH; k++) led_n[k] = (state_n == RUN) & div_n[TAP_BASE-k];
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state  <= IDLE;
      settle <= '0;
      div    <= '0;
      led_o  <= '0;
    end else begin
      state  <= state_n;
      settle <= settle_n;
      div    <= div_n;
      led_o  <= led_n;
    end
  assign locked_o = state == RUN;
  assign state_o  = state;
`ifdef PLL_HB_LOSS_COUNT_EN
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) loss_cnt_o <= '0;
    else if (state == RUN && state_n == LOST && loss_cnt_o != '1) loss_cnt_o <= loss_cnt_o + LOSS_W'(1);
`else
  assign loss_cnt_o = '0;
`endif
endmodule

// File: tb/tb_pll_lock_heartbeat.sv
// tb_pll_lock_heartbeat: directed self-checking bench, CNT_W=8 N_CH=2 TAP_BASE=3 SETTLE_CYC=4 LOSS_W=2.
module tb_pll_lock_heartbeat;
`ifdef PLL_HB_LOSS_COUNT_EN
  localparam bit LC = 1'b1;
`else
  localparam bit LC = 1'b0;
`endif
  logic       clk = 1'b0, rst_i = 1'b0, pll_lock_i = 1'b0, en_i = 1'b0;
  logic [1:0] led_o, state_o, loss_cnt_o;
  logic       locked_o;
  logic [7:0] mdiv = 8'd0;
  int         n_chk = 0, n_fail = 0, losses = 0;
  always #5 clk = ~clk;
  pll_lock_heartbeat #(
    .CNT_W(8), .N_CH(2), .TAP_BASE(3), .SETTLE_CYC(4), .LOSS_W(2)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .pll_lock_i (pll_lock_i),
    .en_i       (en_i),
    .led_o      (led_o),
    .locked_o   (locked_o),
    .state_o    (state_o),
    .loss_cnt_o (loss_cnt_o)
  );
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  function automatic logic [7:0] exp_loss(input int n);
    return LC ? ((n > 3) ? 8'd3 : 8'(n)) : 8'd0;
  endfunction
  task automatic check_hb(input string tag);
    check(tag, 8'(led_o), 8'({mdiv[2], mdiv[3]}));
  endtask
  task automatic go_run();
    pll_lock_i = 1'b1;
    step(2);
    check("sync_latency", 8'(state_o), 8'd0);
    step(1);
    check("settle_entry", 8'(state_o), 8'd1);
    step(3);
    check("settle_hold", 8'(locked_o), 8'd0);
    step(1);
    check("run_state", 8'(state_o), 8'd2);
    check("run_locked", 8'(locked_o), 8'd1);
    mdiv = 8'd0;
  endtask
  task automatic lose();
    pll_lock_i = 1'b0;
    step(2);
    check("loss_sync", 8'(state_o), 8'd2);
    step(1);
    losses++;
    check("lost_state", 8'(state_o), 8'd3);
    check("lost_led", 8'(led_o), 8'd0);
    check("lost_locked", 8'(locked_o), 8'd0);
    check("loss_cnt", 8'(loss_cnt_o), exp_loss(losses));
    step(1);
    check("after_lost", 8'(state_o), 8'd0);
    check("after_lost_led", 8'(led_o), 8'd0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_i = 1'b0; pll_lock_i = 1'b1; en_i = 1'b1;
    step(3);
    check("rst_led", 8'(led_o), 8'd0);
    check("rst_locked", 8'(locked_o), 8'd0);
    check("rst_state", 8'(state_o), 8'd0);
    check("rst_loss", 8'(loss_cnt_o), 8'd0);
    rst_i = 1'b1;
    go_run();
    check_hb("hb_start");
    for (int i = 0; i < 264; i++) begin
      step(1); mdiv++; check_hb("heartbeat");
    end
    en_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1); check_hb("en_hold");
    end
    en_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1); mdiv++; check_hb("resume");
    end
    lose();
    for (int i = 0; i < 4; i++) begin
      go_run();
      lose();
    end
    pll_lock_i = 1'b1;
    step(3);
    check("glitch_settle", 8'(state_o), 8'd1);
    step(1);
    pll_lock_i = 1'b0;
    step(2);
    check("glitch_still_settle", 8'(state_o), 8'd1);
    step(1);
    check("glitch_loss_wins", 8'(state_o), 8'd0);
    check("glitch_locked", 8'(locked_o), 8'd0);
    check("glitch_loss_cnt", 8'(loss_cnt_o), exp_loss(losses));
    go_run();
    for (int i = 0; i < 12; i++) begin
      step(1); mdiv++;
    end
    check("pre_rst_led", 8'(led_o), 8'd3);
    #2 rst_i = 1'b0;
    #1;
    check("async_rst_led", 8'(led_o), 8'd0);
    check("async_rst_locked", 8'(locked_o), 8'd0);
    check("async_rst_state", 8'(state_o), 8'd0);
    check("async_rst_loss", 8'(loss_cnt_o), 8'd0);
    step(2);
    rst_i = 1'b1;
    step(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
